// File: rtl/pair_batch_streamer.sv
// Point buffer that streams each reference line as BATCH_SIZE-lane beats.
// Define PAIR_STREAMER_BEAT_COUNT_EN to add the beat_count output.
module pair_batch_streamer #(
  parameter int MAX_NODE_COUNT = 2000,
  parameter int COORD_BIT_WIDTH = 12,
  parameter int DIMENSIONS = 3,
  parameter int BATCH_SIZE = 16,
  localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_valid,
  input  logic [COORD_BIT_WIDTH-1:0] load_coords [0:DIMENSIONS-1],
  input  logic load_last,
  output logic load_ready,
  output logic [COORD_BIT_WIDTH-1:0]
    batch_coords [0:BATCH_SIZE-1][0:DIMENSIONS-1],
  output logic [INDEX_BIT_WIDTH-1:0] batch_indices [0:BATCH_SIZE-1],
  output logic [BATCH_SIZE-1:0] batch_valid,
  output logic batch_line_end,
  output logic batch_stream_end,
  input  logic batch_ready,
  output logic done
`ifdef PAIR_STREAMER_BEAT_COUNT_EN
  ,
  output logic [31:0] beat_count
`endif
);

  localparam int IW = INDEX_BIT_WIDTH;
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] MAX_N = PW'(MAX_NODE_COUNT);
  localparam logic [PW-1:0] BS_W = PW'(BATCH_SIZE);

  typedef enum logic {S_LOAD, S_STREAM} state_e;

  logic [COORD_BIT_WIDTH-1:0]
    point_mem [0:MAX_NODE_COUNT-1][0:DIMENSIONS-1];

  state_e state_q, state_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] n_q, n_d;
  logic [PW-1:0] ref_q, ref_d;
  logic [PW-1:0] base_q, base_d;

  logic [COORD_BIT_WIDTH-1:0]
    coords_q [0:BATCH_SIZE-1][0:DIMENSIONS-1];
  logic [COORD_BIT_WIDTH-1:0]
    coords_d [0:BATCH_SIZE-1][0:DIMENSIONS-1];
  logic [IW-1:0] idx_q [0:BATCH_SIZE-1];
  logic [IW-1:0] idx_d [0:BATCH_SIZE-1];
  logic [BATCH_SIZE-1:0] valid_q, valid_d;
  logic le_q, le_d;
  logic se_q, se_d;
  logic load_ready_q, load_ready_d;
  logic done_q, done_d;

  logic wr_en;
  logic [IW-1:0] wr_idx;
  logic xfer;

  assign wr_idx = count_q[IW-1:0];
  assign xfer = (|valid_q) && batch_ready;

  always_ff @(posedge clk) begin
    if (wr_en) point_mem[wr_idx] <= load_coords;
  end

  always_comb begin
    logic [PW-1:0] j;
    logic build;
    state_d = state_q;
    count_d = count_q;
    n_d = n_q;
    ref_d = ref_q;
    base_d = base_q;
    coords_d = coords_q;
    idx_d = idx_q;
    valid_d = valid_q;
    le_d = le_q;
    se_d = se_q;
    load_ready_d = load_ready_q;
    done_d = 1'b0;
    wr_en = 1'b0;
    build = 1'b0;
    j = '0;
    unique case (state_q)
      S_LOAD: begin
        if (load_valid) begin
          wr_en = count_q < MAX_N;
          if (wr_en) count_d = count_q + PW'(1);
          if (load_last) begin
            state_d = S_STREAM;
            n_d = wr_en ? count_q + PW'(1) : count_q;
            ref_d = '0;
            base_d = '0;
            load_ready_d = 1'b0;
            build = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (xfer) begin
          unique case (1'b1)
            se_q: begin
              state_d = S_LOAD;
              count_d = '0;
              done_d = 1'b1;
              load_ready_d = 1'b1;
              valid_d = '0;
              le_d = 1'b0;
              se_d = 1'b0;
              for (int k = 0; k < BATCH_SIZE; k++) begin
                idx_d[k] = '0;
                for (int d = 0; d < DIMENSIONS; d++)
                  coords_d[k][d] = '0;
              end
            end
            (le_q && !se_q): begin
              ref_d = ref_q + PW'(1);
              base_d = '0;
              build = 1'b1;
            end
            default: begin
              base_d = base_q + BS_W;
              build = 1'b1;
            end
          endcase
        end
      end
      default: ;
    endcase
    // The last loaded point is still in flight, so forward it
    if (build) begin
      for (int k = 0; k < BATCH_SIZE; k++) begin
        j = ref_d + base_d + PW'(k);
        valid_d[k] = j < n_d;
        idx_d[k] = valid_d[k] ? j[IW-1:0] : '0;
        for (int d = 0; d < DIMENSIONS; d++) begin
          if (!valid_d[k])
            coords_d[k][d] = '0;
          else if (wr_en && (j[IW-1:0] == wr_idx))
            coords_d[k][d] = load_coords[d];
          else
            coords_d[k][d] = point_mem[j[IW-1:0]][d];
        end
      end
      le_d = (ref_d + base_d + BS_W) >= n_d;
      se_d = le_d && ((ref_d + PW'(2)) >= n_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      count_q <= '0;
      n_q <= '0;
      ref_q <= '0;
      base_q <= '0;
      valid_q <= '0;
      le_q <= 1'b0;
      se_q <= 1'b0;
      load_ready_q <= 1'b1;
      done_q <= 1'b0;
      for (int k = 0; k < BATCH_SIZE; k++) begin
        idx_q[k] <= '0;
        for (int d = 0; d < DIMENSIONS; d++)
          coords_q[k][d] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_q <= n_d;
      ref_q <= ref_d;
      base_q <= base_d;
      valid_q <= valid_d;
      le_q <= le_d;
      se_q <= se_d;
      load_ready_q <= load_ready_d;
      done_q <= done_d;
      idx_q <= idx_d;
      coords_q <= coords_d;
    end
  end

  assign load_ready = load_ready_q;
  assign batch_coords = coords_q;
  assign batch_indices = idx_q;
  assign batch_valid = valid_q;
  assign batch_line_end = le_q;
  assign batch_stream_end = se_q;
  assign done = done_q;

`ifdef PAIR_STREAMER_BEAT_COUNT_EN
  logic [31:0] beat_count_q, beat_count_d;

  always_comb begin
    beat_count_d = beat_count_q;
    if (state_q == S_LOAD && load_valid && load_last)
      beat_count_d = '0;
    else if (state_q == S_STREAM && xfer)
      beat_count_d = beat_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_count_q <= '0;
    else beat_count_q <= beat_count_d;
  end

  assign beat_count = beat_count_q;
`endif

endmodule
